ifetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decoder.
- Owns the PC and issues one outstanding read at a time to the instruction memory/icache over a req/ready + rvalid handshake.
- Delivers {instruction, PC, PC+4, valid} through an IF/ID output register that the decoder consumes.
- Handles stall, redirect (jump/branch/jr target) and flush, including discarding responses that arrive after a redirect.

---
 rtl/ifetch_stage.sv | 143 ++++++++++++++
 tb/tb_ifetch_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem read in flight,
// and presents {ins, pc, pc+4, valid} to the decoder through the IF/ID register.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ins_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        ins_valid_o,
    output logic [1:0]  fsm_state_o
);

    // Handshake: a request transfers on a cycle where imem_req_o && imem_ready_i;
    // its single response arrives on a later cycle with imem_rvalid_i (no backpressure).
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        deliver;
    logic [31:0] dlv_ins, dlv_pc;
    logic [31:0] target_pc;
    logic        unused_low_bits;

    assign target_pc       = {redirect_pc_i[31:2], 2'b00};
    assign unused_low_bits = ^redirect_pc_i[1:0];

    assign imem_req_o  = (state_q == S_REQ) && !redirect_i && !rst;
    assign imem_addr_o = pc_q;
    assign fsm_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        buf_d      = buf_q;
        buf_pc_d   = buf_pc_q;
        deliver    = 1'b0;
        dlv_ins    = buf_q;
        dlv_pc     = buf_pc_q;
        case (state_q)
            S_REQ: begin
                if (redirect_i) begin
                    pc_d = target_pc;
                end else if (imem_ready_i) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (redirect_i) begin
                        pc_d    = target_pc;
                        state_d = S_REQ;
                    end else if (stall_i) begin
                        buf_d    = imem_rdata_i;
                        buf_pc_d = fetch_pc_q;
                        state_d  = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                        dlv_ins = imem_rdata_i;
                        dlv_pc  = fetch_pc_q;
                        state_d = S_REQ;
                    end
                end else if (redirect_i) begin
                    pc_d    = target_pc;
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                // The stale response is still owed by memory; swallow it before refetching.
                if (redirect_i) pc_d = target_pc;
                if (imem_rvalid_i) state_d = S_REQ;
            end
            S_HOLD: begin
                if (redirect_i) begin
                    pc_d    = target_pc;
                    state_d = S_REQ;
                end else if (!stall_i) begin
                    deliver = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            buf_q       <= 32'h0;
            buf_pc_q    <= RESET_PC;
            ins_o       <= 32'h0;
            pc_o        <= RESET_PC;
            pc_plus4_o  <= RESET_PC + 32'd4;
            ins_valid_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            buf_q      <= buf_d;
            buf_pc_q   <= buf_pc_d;
            // Flush keeps pc_o/pc_plus4_o so the bubble still carries a sane PC.
            if (flush_i) begin
                ins_o       <= 32'h0;
                ins_valid_o <= 1'b0;
            end else if (stall_i) begin
                ins_o       <= ins_o;
                ins_valid_o <= ins_valid_o;
            end else if (deliver) begin
                ins_o       <= dlv_ins;
                pc_o        <= dlv_pc;
                pc_plus4_o  <= dlv_pc + 32'd4;
                ins_valid_o <= 1'b1;
            end else begin
                ins_o       <= 32'h0;
                ins_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed scenarios then random traffic, all checked
// against a transaction-level model (in-flight flag, held slot, drop flag).
module tb_ifetch_stage;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0, flush_i = 1'b0, redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_ready_i = 1'b0, imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o, ins_o, pc_o, pc_plus4_o;
    logic        ins_valid_o;
    logic [1:0]  state_unused_a;

    // Second instance exercising the top-of-address-space wrap.
    logic        w_rst = 1'b1, w_ready = 1'b0, w_rvalid = 1'b0;
    logic [31:0] w_rdata = 32'h0;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_ins, w_pc, w_pc4;
    logic [1:0]  state_unused_b;
    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = 32'h0;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 sys_clk = ~sys_clk;

    ifetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .sys_clk(sys_clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .ins_o(ins_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .ins_valid_o(ins_valid_o),
        .fsm_state_o(state_unused_a)
    );

    ifetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .sys_clk(sys_clk), .rst(w_rst), .stall_i(w_zero), .flush_i(w_zero),
        .redirect_i(w_zero), .redirect_pc_i(w_zero32),
        .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_ready_i(w_ready), .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
        .ins_o(w_ins), .pc_o(w_pc), .pc_plus4_o(w_pc4), .ins_valid_o(w_valid),
        .fsm_state_o(state_unused_b)
    );

    // Reference model state
    logic [31:0] m_pc = 32'h0, m_fetch_pc = 32'h0;
    bit          m_inflight = 0, m_drop = 0, m_held = 0;
    logic [31:0] m_held_ins = 32'h0, m_held_pc = 32'h0;
    logic [31:0] e_ins = 32'h0, e_pc = 32'h0, e_pc4 = 32'h4;
    bit          e_valid = 0;
    // Memory model
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_data = 32'h0;
    bit          ovr_en = 0;
    logic [31:0] ovr_data = 32'h0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check request side, advance model, check IF/ID after the edge.
    task automatic cycle(input bit r, input bit st, input bit fl, input bit rd,
                         input logic [31:0] tg, input bit rdy, input int lat);
        bit          rv, exp_req, accept, dlv;
        logic [31:0] rdat, tgt, pc_nx, d_ins, d_pc;
        @(negedge sys_clk);
        rv   = mem_busy && (mem_cnt == 0);
        rdat = mem_data;
        rst = r; stall_i = st; flush_i = fl; redirect_i = rd; redirect_pc_i = tg;
        imem_ready_i = rdy; imem_rvalid_i = rv;
        imem_rdata_i = rv ? rdat : $urandom;
        #1;
        exp_req = !r && !m_inflight && !m_held && !rd;
        chk("imem_req", imem_req_o, exp_req);
        if (!r) chk("imem_addr", imem_addr_o, m_pc);
        accept = exp_req && rdy;
        dlv = 0; d_ins = 32'h0; d_pc = 32'h0;
        tgt = {tg[31:2], 2'b00};
        if (r) begin
            m_pc = 32'h0; m_inflight = 0; m_drop = 0; m_held = 0;
            e_ins = 32'h0; e_pc = 32'h0; e_pc4 = 32'h4; e_valid = 0;
            mem_busy = 0;
        end else begin
            pc_nx = rd ? tgt : m_pc;
            if (m_inflight && rv) begin
                m_inflight = 0;
                if (!(m_drop || rd)) begin
                    if (st) begin
                        m_held = 1; m_held_ins = rdat; m_held_pc = m_fetch_pc;
                    end else begin
                        dlv = 1; d_ins = rdat; d_pc = m_fetch_pc;
                    end
                end
                m_drop = 0;
            end else if (m_inflight && rd) begin
                m_drop = 1;
            end else if (m_held) begin
                if (rd) m_held = 0;
                else if (!st) begin
                    dlv = 1; d_ins = m_held_ins; d_pc = m_held_pc; m_held = 0;
                end
            end
            if (accept) begin
                m_inflight = 1; m_drop = 0; m_fetch_pc = m_pc; pc_nx = m_pc + 32'd4;
                mem_busy = 1; mem_cnt = lat;
                mem_data = ovr_en ? ovr_data : word_at(m_pc);
                ovr_en = 0;
            end else if (mem_busy) begin
                if (rv) mem_busy = 0;
                else mem_cnt--;
            end
            m_pc = pc_nx;
            if (fl) begin
                e_ins = 32'h0; e_valid = 0;
            end else if (!st) begin
                if (dlv) begin
                    e_ins = d_ins; e_pc = d_pc; e_pc4 = d_pc + 32'd4; e_valid = 1;
                end else begin
                    e_ins = 32'h0; e_valid = 0;
                end
            end
        end
        @(posedge sys_clk);
        #1;
        chk("ins_o", ins_o, e_ins);
        chk("pc_o", pc_o, e_pc);
        chk("pc_plus4_o", pc_plus4_o, e_pc4);
        chk("ins_valid_o", ins_valid_o, e_valid);
    endtask

    initial begin
        // Reset
        cycle(1, 0, 0, 0, 32'h0, 0, 0);
        cycle(1, 0, 0, 0, 32'h0, 0, 0);
        chk("reset_pc4", pc_plus4_o, 32'h4);

        // Zero-latency memory: fetches at 0x0, 0x4, 0x8, one every 2 cycles
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 32'h0, 1, 0);
        chk("zl_last_pc", pc_o, 32'h8);
        chk("zl_last_valid", ins_valid_o, 1);

        // Stall while the response arrives: held, then delivered exactly once
        ovr_en = 1; ovr_data = 32'h2408_0005;
        cycle(0, 0, 0, 0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 32'h0, 1, 0);
        cycle(0, 0, 0, 0, 32'h0, 0, 0);
        chk("stall_release_ins", ins_o, 32'h2408_0005);
        chk("stall_release_pc", pc_o, 32'hC);
        cycle(0, 0, 0, 0, 32'h0, 0, 0);
        chk("stall_once", ins_valid_o, 0);

        // Redirect while waiting: stale response dropped, refetch at 0x100
        cycle(0, 0, 0, 0, 32'h0, 1, 2);
        cycle(0, 0, 0, 1, 32'h0000_0103, 1, 0);
        cycle(0, 0, 0, 0, 32'h0, 1, 0);
        cycle(0, 0, 0, 0, 32'h0, 0, 0);
        chk("drop_valid", ins_valid_o, 0);
        chk("drop_next_addr", imem_addr_o, 32'h100);

        // Redirect coinciding with rvalid, then redirect in REQ with ready high
        cycle(0, 0, 0, 0, 32'h0, 1, 0);
        cycle(0, 0, 0, 1, 32'h0000_0200, 1, 0);
        chk("rv_redir_valid", ins_valid_o, 0);
        chk("rv_redir_addr", imem_addr_o, 32'h200);
        cycle(0, 0, 0, 1, 32'h0000_0302, 1, 0);
        chk("req_redir_addr", imem_addr_o, 32'h300);

        // Flush beats stall
        cycle(0, 0, 0, 0, 32'h0, 1, 0);
        cycle(0, 0, 0, 0, 32'h0, 0, 0);
        chk("pre_flush_valid", ins_valid_o, 1);
        cycle(0, 1, 1, 0, 32'h0, 0, 0);
        chk("flush_valid", ins_valid_o, 0);
        chk("flush_ins", ins_o, 32'h0);
        chk("flush_pc_kept", pc_o, 32'h300);

        // Reset in the middle of a wait
        cycle(0, 0, 0, 0, 32'h0, 1, 2);
        cycle(1, 0, 0, 0, 32'h0, 1, 0);
        chk("midrst_pc", pc_o, 32'h0);
        cycle(0, 0, 0, 0, 32'h0, 1, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 2));
        end

        // Wrap instance: RESET_PC = 0xFFFF_FFFC
        @(negedge sys_clk); w_rst = 1;
        @(negedge sys_clk); w_rst = 0; w_ready = 0;
        #1;
        chk("wrap_req", w_req, 1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        chk("wrap_rst_pc4", w_pc4, 32'h0);
        @(negedge sys_clk); w_ready = 1;
        @(negedge sys_clk); w_ready = 0; w_rvalid = 1; w_rdata = 32'hCAFE_0001;
        #1;
        chk("wrap_addr1", w_addr, 32'h0);
        chk("wrap_req_wait", w_req, 0);
        @(posedge sys_clk); #1;
        chk("wrap_ins", w_ins, 32'hCAFE_0001);
        chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", w_pc4, 32'h0);
        chk("wrap_valid", w_valid, 1);
        @(negedge sys_clk); w_rvalid = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
